// File: rtl/screen_fill_engine_pkg.sv
// ---------------------------------------------------------------------------
// screen_fill_engine_pkg
// Shared definitions for the full-screen fill engine:
//   - fill mode encodings (solid, image ROM, border, checkerboard)
//   - sweep FSM state encodings
//   - default colour constants for the 3-bit RGB 1-1-1 palette
// ---------------------------------------------------------------------------
package screen_fill_engine_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_IMAGE   = 2'd1,
        MODE_BORDER  = 2'd2,
        MODE_CHECKER = 2'd3
    } fill_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } fill_state_e;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;

endpackage

// File: rtl/screen_fill_engine_if.sv
// ---------------------------------------------------------------------------
// screen_fill_engine_if
// Bundles the fill engine's control, image ROM and plot-port signals.
// Names are seen from the engine: i_* flow into it, o_* flow out of it.
//   i_start        sweep request (sampled only while idle)
//   i_mode         fill mode, see fill_mode_e
//   i_fill_colour  colour for solid / border / checker modes
//   i_rom_data     image ROM read data
//   o_rom_addr     image ROM linear address y*W+x
//   o_x, o_y       pixel coordinates
//   o_colour       pixel colour
//   o_plot         write strobe, one pixel per asserted cycle
//   o_busy         sweep in progress
//   o_done         one-cycle completion pulse
// Modports: master = game FSM / ROM side, slave = fill engine.
// ---------------------------------------------------------------------------
interface screen_fill_engine_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int ADDR_W   = 15
);
    logic                i_start;
    logic [1:0]          i_mode;
    logic [COLOUR_W-1:0] i_fill_colour;
    logic [COLOUR_W-1:0] i_rom_data;
    logic [ADDR_W-1:0]   o_rom_addr;
    logic [X_W-1:0]      o_x;
    logic [Y_W-1:0]      o_y;
    logic [COLOUR_W-1:0] o_colour;
    logic                o_plot;
    logic                o_busy;
    logic                o_done;

    modport master (
        output i_start, i_mode, i_fill_colour, i_rom_data,
        input  o_rom_addr, o_x, o_y, o_colour, o_plot, o_busy, o_done
    );

    modport slave (
        input  i_start, i_mode, i_fill_colour, i_rom_data,
        output o_rom_addr, o_x, o_y, o_colour, o_plot, o_busy, o_done
    );
endinterface

// File: rtl/screen_fill_engine_raster_counter.sv
// ---------------------------------------------------------------------------
// screen_raster_counter
// Raster-order x/y counter with a parallel linear address counter, so the
// ROM address never needs a y*W multiply.
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clear      return to pixel (0,0)
//   i_advance    step to the next pixel in raster order
//   o_x, o_y     current pixel
//   o_addr       current linear address
//   o_last       current pixel is (SCREEN_W-1, SCREEN_H-1)
// ---------------------------------------------------------------------------
module screen_raster_counter
    import screen_fill_engine_pkg::*;
#(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_advance,
    output logic [X_W-1:0]    o_x,
    output logic [Y_W-1:0]    o_y,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);
    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [ADDR_W-1:0] r_addr;
    logic              w_xEnd;

    assign w_xEnd = (r_x == X_LAST);
    assign o_last = w_xEnd && (r_y == Y_LAST);
    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_addr = r_addr;

    // After the last pixel everything wraps to zero so the idle address is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_clear || (i_advance && o_last)) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_advance) begin
            r_addr <= r_addr + 1'b1;
            if (w_xEnd) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end
endmodule

// File: rtl/screen_fill_engine.sv
// ---------------------------------------------------------------------------
// screen_fill_engine
// On a start request, sweeps every pixel of a SCREEN_W x SCREEN_H frame once
// in raster order and emits one plot per pixel. x/y/mode travel through a
// ROM_LAT-deep pipeline so they meet the image ROM data, then through one
// output register; every mode therefore has the same ROM_LAT+1 latency.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          screen_fill_engine_if.slave (control, ROM, plot port)
// Build option: SCREEN_FILL_PATTERN_EN enables border and checkerboard
// modes; without it those modes paint solid fill colour.
// ---------------------------------------------------------------------------
module screen_fill_engine
    import screen_fill_engine_pkg::*;
#(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int ADDR_W   = 15,
    parameter int ROM_LAT  = 1
) (
    input logic clk,
    input logic rst_n,
    screen_fill_engine_if.slave bus
);
    localparam int DCNT_W = $clog2(ROM_LAT + 1) + 1;

    fill_state_e         r_state, w_nextState;
    fill_mode_e          r_mode;
    logic [COLOUR_W-1:0] r_fill;
    logic [DCNT_W-1:0]   r_drainCnt;
    logic                r_done;
    logic                w_accept, w_advance, w_drainEnd;

    logic [X_W-1:0]      w_issueX;
    logic [Y_W-1:0]      w_issueY;
    logic                w_issueLast;

    logic                r_pipeValid [ROM_LAT];
    logic [X_W-1:0]      r_pipeX     [ROM_LAT];
    logic [Y_W-1:0]      r_pipeY     [ROM_LAT];
    fill_mode_e          r_pipeMode  [ROM_LAT];

    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_plot;
    logic [COLOUR_W-1:0] w_pixColour;

    screen_raster_counter #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .X_W      (X_W),
        .Y_W      (Y_W),
        .ADDR_W   (ADDR_W)
    ) u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_accept),
        .i_advance (w_advance),
        .o_x       (w_issueX),
        .o_y       (w_issueY),
        .o_addr    (bus.o_rom_addr),
        .o_last    (w_issueLast)
    );

    // DRAIN holds for ROM_LAT+1 cycles, exactly long enough for the last
    // issued pixel to reach the output register.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        w_drainEnd  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_accept    = 1'b1;
                    w_nextState = SWEEP;
                end
            end
            SWEEP: begin
                w_advance = 1'b1;
                if (w_issueLast) w_nextState = DRAIN;
            end
            DRAIN: begin
                if (r_drainCnt == DCNT_W'(ROM_LAT)) begin
                    w_drainEnd  = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Mode and fill colour are captured once at acceptance and held for the
    // whole sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_mode     <= MODE_SOLID;
            r_fill     <= '0;
            r_drainCnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_done     <= w_drainEnd;
            r_drainCnt <= (r_state == DRAIN) ? r_drainCnt + 1'b1 : '0;
            if (w_accept) begin
                r_mode <= fill_mode_e'(bus.i_mode);
                r_fill <= bus.i_fill_colour;
            end
        end
    end

    // Alignment pipeline: the tail stage lines up with i_rom_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                r_pipeValid[i] <= 1'b0;
                r_pipeX[i]     <= '0;
                r_pipeY[i]     <= '0;
                r_pipeMode[i]  <= MODE_SOLID;
            end
        end else begin
            r_pipeValid[0] <= (r_state == SWEEP);
            r_pipeX[0]     <= w_issueX;
            r_pipeY[0]     <= w_issueY;
            r_pipeMode[0]  <= r_mode;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_pipeValid[i] <= r_pipeValid[i-1];
                r_pipeX[i]     <= r_pipeX[i-1];
                r_pipeY[i]     <= r_pipeY[i-1];
                r_pipeMode[i]  <= r_pipeMode[i-1];
            end
        end
    end

`ifdef SCREEN_FILL_PATTERN_EN
    logic w_onEdge;
    assign w_onEdge = (r_pipeX[ROM_LAT-1] == '0) ||
                      (r_pipeX[ROM_LAT-1] == X_W'(SCREEN_W - 1)) ||
                      (r_pipeY[ROM_LAT-1] == '0) ||
                      (r_pipeY[ROM_LAT-1] == Y_W'(SCREEN_H - 1));
`endif

    // Colour selection at the pipeline tail.
    always_comb begin
        w_pixColour = r_fill;
        case (r_pipeMode[ROM_LAT-1])
            MODE_IMAGE: w_pixColour = bus.i_rom_data;
`ifdef SCREEN_FILL_PATTERN_EN
            MODE_BORDER: begin
                if (!w_onEdge) w_pixColour = COLOUR_W'(BLACK);
            end
            MODE_CHECKER: begin
                if (!(r_pipeX[ROM_LAT-1][0] ^ r_pipeY[ROM_LAT-1][0]))
                    w_pixColour = COLOUR_W'(BLACK);
            end
`endif
            default: w_pixColour = r_fill;
        endcase
    end

    // Registered plot port; coordinates and colour hold between plots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
        end else begin
            r_plot <= r_pipeValid[ROM_LAT-1];
            if (r_pipeValid[ROM_LAT-1]) begin
                r_x      <= r_pipeX[ROM_LAT-1];
                r_y      <= r_pipeY[ROM_LAT-1];
                r_colour <= w_pixColour;
            end
        end
    end

    assign bus.o_x      = r_x;
    assign bus.o_y      = r_y;
    assign bus.o_colour = r_colour;
    assign bus.o_plot   = r_plot;
    assign bus.o_busy   = (r_state != IDLE);
    assign bus.o_done   = r_done;
endmodule
